// File: rtl/rf_codec_pkg.sv
// Shared types and interval-window helpers for the Manchester receive path.
package rf_codec_pkg;

    // Decoder lock state.
    typedef enum logic [0:0] {
        StHunt,
        StLocked
    } dec_state_e;

    // Classification of the time elapsed since the last mid-bit edge.
    typedef enum logic [1:0] {
        ClsShort,
        ClsLong,
        ClsGlitch,
        ClsTimeout
    } interval_cls_e;

    // Lower bound of a SHORT (half-bit) interval.
    function automatic int unsigned short_lo(input int unsigned osr);
        return osr / 2;
    endfunction

    // Lower bound of a LONG (full-bit) interval.
    function automatic int unsigned long_lo(input int unsigned osr);
        return (3 * osr) / 2;
    endfunction

    // Upper bound (inclusive) of a LONG interval; anything beyond is a timeout.
    function automatic int unsigned long_hi(input int unsigned osr);
        return (5 * osr) / 2;
    endfunction

    // Saturation value of the interval counter.
    function automatic int unsigned cnt_max(input int unsigned osr);
        return 3 * osr;
    endfunction

    // Map an elapsed-cycle count onto its interval class.
    function automatic interval_cls_e classify(input int unsigned cnt, input int unsigned osr);
        if (cnt < short_lo(osr)) begin
            return ClsGlitch;
        end else if (cnt < long_lo(osr)) begin
            return ClsShort;
        end else if (cnt <= long_hi(osr)) begin
            return ClsLong;
        end
        return ClsTimeout;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Line conditioning for the Manchester decoder: 2-flop synchronizer, optional
// 3-sample majority filter (MANCHESTER_DEC_GLITCH_FILTER_EN) and edge detect.
// The edge strobe is combinational from the conditioned level so the decoder
// registers it 3 cycles after a din transition (4 with the filter).
module edge_sync
    import rf_codec_pkg::*;
(
    input  logic clk2x_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic level_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    // Bring the asynchronous line into the clk2x domain.
    always_ff @(posedge clk2x_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MANCHESTER_DEC_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;

    // Sample history for the majority vote; a lone 1-sample pulse never wins.
    always_ff @(posedge clk2x_i) begin
        if (!rst_ni) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    assign level = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign level = sync2_q;
`endif

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clk2x_i) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign edge_o  = level ^ prev_q;

endmodule

// File: rtl/manchester_decoder.sv
// Oversampling Manchester decoder (bit 1 = high->low mid-bit, bit 0 = low->high).
// Locks on the first full-bit interval between mid-bit edges, then tracks every
// mid-bit edge and flags timing violations. Optional glitch filter is enabled
// with MANCHESTER_DEC_GLITCH_FILTER_EN (adds one cycle of latency).
module manchester_decoder
    import rf_codec_pkg::*;
#(
    parameter int unsigned OSR = 8
) (
    input  logic clk2x,
    input  logic rst_n,
    input  logic enable,
    input  logic din,
    output logic dout,
    output logic valid,
    output logic locked,
    output logic err
);

    localparam int unsigned CNT_W = $clog2(3 * OSR + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(OSR));
    // The edge cycle itself is the first cycle of the new interval, so a run of
    // N cycles between edge strobes reads back as cnt == N.
    localparam logic [CNT_W-1:0] CntRestart = CNT_W'(1);

    logic          level;
    logic          edge_stb;
    dec_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          started_q, started_d;
    logic          seen_q, seen_d;
    logic          dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    interval_cls_e cls;

    edge_sync u_edge_sync (
        .clk2x_i (clk2x),
        .rst_ni  (rst_n),
        .din_i   (din),
        .level_o (level),
        .edge_o  (edge_stb)
    );

    // Lock FSM, interval counter and bit-emit decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
        started_d = started_q;
        seen_d    = seen_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cls       = classify(32'(cnt_q), OSR);

        if (!enable) begin
            state_d   = StHunt;
            cnt_d     = '0;
            started_d = 1'b0;
            seen_d    = 1'b0;
            dout_d    = 1'b0;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (edge_stb) begin
                        // Only a full-bit gap guarantees both edges were mid-bit.
                        cnt_d     = CntRestart;
                        started_d = 1'b1;
                        seen_d    = 1'b0;
                        if (started_q && (cls == ClsLong)) begin
                            dout_d  = ~level;
                            valid_d = 1'b1;
                            state_d = StLocked;
                        end
                    end
                end
                StLocked: begin
                    if (edge_stb) begin
                        if (cls == ClsLong) begin
                            dout_d  = ~level;
                            valid_d = 1'b1;
                            cnt_d   = CntRestart;
                            seen_d  = 1'b0;
                        end else if ((cls == ClsShort) && !seen_q) begin
                            // Bit-boundary edge: keep timing from the last mid-bit edge.
                            seen_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StHunt;
                            cnt_d   = CntRestart;
                            seen_d  = 1'b0;
                        end
                    end else if (cls == ClsTimeout) begin
                        err_d   = 1'b1;
                        state_d = StHunt;
                        seen_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk2x) begin
        if (!rst_n) begin
            state_q   <= StHunt;
            cnt_q     <= '0;
            started_q <= 1'b0;
            seen_q    <= 1'b0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            seen_q    <= seen_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // enable gates the outputs combinationally so an abort silences them at once.
    assign dout   = dout_q & enable;
    assign valid  = valid_q & enable;
    assign err    = err_q & enable;
    assign locked = (state_q == StLocked) & enable;

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed self-checking bench for manchester_decoder at OSR=8.
// Honours MANCHESTER_DEC_GLITCH_FILTER_EN for the latency/glitch expectations.
module tb_manchester_decoder;

    localparam int unsigned OSR = 8;
    localparam int unsigned H = OSR;
`ifdef MANCHESTER_DEC_GLITCH_FILTER_EN
    localparam int LAT = 4;
    localparam int GLITCH_ERRS = 0;
`else
    localparam int LAT = 3;
    localparam int GLITCH_ERRS = 1;
`endif
    localparam int TO_DLY = 21;

    logic clk2x = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic din = 1'b0;
    logic dout;
    logic valid;
    logic locked;
    logic err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int   v_cyc[$];
    logic v_bit[$];
    int   e_cyc[$];
    int   mid_cyc[$];

    manchester_decoder #(.OSR(OSR)) dut (
        .clk2x  (clk2x),
        .rst_n  (rst_n),
        .enable (enable),
        .din    (din),
        .dout   (dout),
        .valid  (valid),
        .locked (locked),
        .err    (err)
    );

    always #5 clk2x = ~clk2x;

    always @(posedge clk2x) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge clk2x) begin
        if (valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_bit.push_back(dout);
        end
        if (err === 1'b1) e_cyc.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk2x);
            #1;
        end
    endtask

    task automatic half(input logic lvl, input int n);
        din = lvl;
        step(n);
    endtask

    task automatic send_bit(input logic b, input int h1, input int h2);
        half(b, h1);
        mid_cyc.push_back(cyc);
        half(~b, h2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        din = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(2);
        v_cyc.delete();
        v_bit.delete();
        e_cyc.delete();
        mid_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        din = 1'b0;
        step(2);
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        step(40);
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL idle_hunt_err: got %0d pulses want 0", e_cyc.size()); end
        checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL idle_hunt_valid: got %0d strobes want 0", v_cyc.size()); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_hunt_locked: got %b want 0", locked); end
    endtask

    task automatic test_stream();
        logic exp_b[4];
        int n;
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        send_bit(1'b1, H, H);
        send_bit(1'b0, H, H);
        send_bit(1'b1, H, H);
        send_bit(1'b1, H, H);
        send_bit(1'b0, H, H);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stream_locked: got %b want 1", locked); end
        step(30);
        checks++; if (v_cyc.size() != 4) begin errors++; $display("FAIL stream_count: got %0d want 4", v_cyc.size()); end
        n = (v_cyc.size() < 4) ? v_cyc.size() : 4;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (v_bit[i] !== exp_b[i]) begin
                errors++; $display("FAIL stream_bit%0d: got %b want %b", i, v_bit[i], exp_b[i]);
            end
            checks++;
            if (v_cyc[i] != mid_cyc[i+1] + LAT) begin
                errors++; $display("FAIL stream_lat%0d: got cyc %0d want %0d", i, v_cyc[i], mid_cyc[i+1] + LAT);
            end
        end
        checks++; if (e_cyc.size() != 1) begin errors++; $display("FAIL idle_err_count: got %0d want 1", e_cyc.size()); end
        if (e_cyc.size() >= 1 && v_cyc.size() >= 1) begin
            checks++;
            if (e_cyc[0] != v_cyc[v_cyc.size()-1] + TO_DLY) begin
                errors++; $display("FAIL idle_err_time: got cyc %0d want %0d", e_cyc[0], v_cyc[v_cyc.size()-1] + TO_DLY);
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked: got %b want 0", locked); end
    endtask

    task automatic test_all_ones();
        do_reset();
        send_bit(1'b1, H, H);
        send_bit(1'b0, H, H);
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1, H, H);
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL ones_locked%0d: got %b want 1", i, locked); end
        end
        checks++; if (v_cyc.size() != 7) begin errors++; $display("FAIL ones_count: got %0d want 7", v_cyc.size()); end
        for (int i = 1; i < v_cyc.size(); i++) begin
            checks++;
            if (v_bit[i] !== 1'b1) begin errors++; $display("FAIL ones_bit%0d: got %b want 1", i, v_bit[i]); end
        end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL ones_err: got %0d pulses want 0", e_cyc.size()); end
    endtask

    task automatic test_jitter();
        logic exp_b[3];
        int n;
        exp_b = '{1'b0, 1'b1, 1'b0};
        do_reset();
        send_bit(1'b1, H, H);
        send_bit(1'b0, H, H);
        send_bit(1'b1, 4, H);    // mid-to-mid 12
        send_bit(1'b0, 12, H);   // mid-to-mid 20
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL jitter_locked: got %b want 1", locked); end
        send_bit(1'b1, 13, H);   // mid-to-mid 21
        step(4);
        checks++; if (v_cyc.size() != 3) begin errors++; $display("FAIL jitter_count: got %0d want 3", v_cyc.size()); end
        n = (v_cyc.size() < 3) ? v_cyc.size() : 3;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (v_bit[i] !== exp_b[i]) begin errors++; $display("FAIL jitter_bit%0d: got %b want %b", i, v_bit[i], exp_b[i]); end
        end
        checks++; if (e_cyc.size() != 1) begin errors++; $display("FAIL jitter_err_count: got %0d want 1", e_cyc.size()); end
        if (e_cyc.size() >= 1) begin
            checks++;
            if (e_cyc[0] != mid_cyc[4] + LAT) begin
                errors++; $display("FAIL jitter_err_time: got cyc %0d want %0d", e_cyc[0], mid_cyc[4] + LAT);
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL jitter_unlock: got %b want 0", locked); end
    endtask

    task automatic test_glitch();
        logic exp_b[4];
        int n;
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        send_bit(1'b1, H, H);
        half(1'b0, H);
        mid_cyc.push_back(cyc);
        half(1'b1, 3);
        half(1'b0, 1);           // single-sample glitch
        half(1'b1, 4);
        send_bit(1'b1, H, H);
        send_bit(1'b0, H, H);
        send_bit(1'b1, H, H);
        checks++; if (v_cyc.size() != 4) begin errors++; $display("FAIL glitch_count: got %0d want 4", v_cyc.size()); end
        n = (v_cyc.size() < 4) ? v_cyc.size() : 4;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (v_bit[i] !== exp_b[i]) begin errors++; $display("FAIL glitch_bit%0d: got %b want %b", i, v_bit[i], exp_b[i]); end
            checks++;
            if (v_cyc[i] != mid_cyc[i+1] + LAT) begin
                errors++; $display("FAIL glitch_lat%0d: got cyc %0d want %0d", i, v_cyc[i], mid_cyc[i+1] + LAT);
            end
        end
        checks++;
        if (e_cyc.size() != GLITCH_ERRS) begin
            errors++; $display("FAIL glitch_err_count: got %0d want %0d", e_cyc.size(), GLITCH_ERRS);
        end
`ifndef MANCHESTER_DEC_GLITCH_FILTER_EN
        if (e_cyc.size() >= 1) begin
            checks++;
            if (e_cyc[0] != mid_cyc[1] + 3 + LAT) begin
                errors++; $display("FAIL glitch_err_time: got cyc %0d want %0d", e_cyc[0], mid_cyc[1] + 3 + LAT);
            end
        end
`endif
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_relock: got %b want 1", locked); end
    endtask

    // mode 0: drop enable for 5 cycles; mode 1: pulse rst_n low for 1 cycle.
    task automatic test_abort(input int mode);
        logic exp_b[3];
        int n;
        exp_b = '{1'b1, 1'b1, 1'b0};
        do_reset();
        send_bit(1'b0, H, H);
        send_bit(1'b1, H, H);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort%0d_prelock: got %b want 1", mode, locked); end
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL abort%0d_predout: got %b want 1", mode, dout); end
        half(1'b0, 2);
        if (mode == 0) enable = 1'b0;
        else rst_n = 1'b0;
        step(1);
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL abort%0d_dout: got %b want 0", mode, dout); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort%0d_locked: got %b want 0", mode, locked); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort%0d_valid: got %b want 0", mode, valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort%0d_err: got %b want 0", mode, err); end
        if (mode == 0) begin
            step(4);
            enable = 1'b1;
            half(1'b0, 1);
        end else begin
            rst_n = 1'b1;
            half(1'b0, 5);
        end
        mid_cyc.push_back(cyc);
        half(1'b1, H);
        send_bit(1'b1, H, H);
        send_bit(1'b0, H, H);
        checks++; if (v_cyc.size() != 3) begin errors++; $display("FAIL abort%0d_count: got %0d want 3", mode, v_cyc.size()); end
        n = (v_cyc.size() < 3) ? v_cyc.size() : 3;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (v_bit[i] !== exp_b[i]) begin errors++; $display("FAIL abort%0d_bit%0d: got %b want %b", mode, i, v_bit[i], exp_b[i]); end
        end
        if (v_cyc.size() == 3) begin
            checks++;
            if (v_cyc[1] != mid_cyc[3] + LAT) begin
                errors++; $display("FAIL abort%0d_relock_time: got cyc %0d want %0d", mode, v_cyc[1], mid_cyc[3] + LAT);
            end
        end
        checks++; if (e_cyc.size() != 0) begin errors++; $display("FAIL abort%0d_errs: got %0d want 0", mode, e_cyc.size()); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort%0d_relock: got %b want 1", mode, locked); end
    endtask

    initial begin
        step(1);
        test_reset();
        test_stream();
        test_all_ones();
        test_jitter();
        test_glitch();
        test_abort(0);
        test_abort(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
